// File: rtl/reg_rst_y_mode_a_en_n_core.sv
// Free-running D-type register stage with a synchronous active-low reset.
// o_data is driven straight from the state register, so nothing from i_data reaches it combinationally.
module reg_rst_y_mode_a_en_n_core #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    RST_DATA   = {DATA_WIDTH{1'b0}}
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Next-state selection: the reset value overrides the captured data.
  always_comb begin
    data_d = data_q;
    if (!i_rst_n) begin
      data_d = RST_DATA;
    end else begin
      data_d = i_data;
    end
  end

  // State register; reset is evaluated only at the rising clock edge.
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_reg_rst_y_mode_a_en_n_core.sv
// Directed bench for the register stage: a default 32-bit build and an 8-bit build
// whose reset value is 8'hA5.
module tb_reg_rst_y_mode_a_en_n_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        rst8_n;
  logic [7:0]  data8_in;
  logic [7:0]  data8_out;

  int tests_run;
  int tests_failed;

  reg_rst_y_mode_a_en_n_core #(
    .DATA_WIDTH(32),
    .RST_DATA  (32'h0000_0000)
  ) dut32 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (data_in),
    .o_data (data_out)
  );

  reg_rst_y_mode_a_en_n_core #(
    .DATA_WIDTH(8),
    .RST_DATA  (8'hA5)
  ) dut8 (
    .i_clk  (clk),
    .i_rst_n(rst8_n),
    .i_data (data8_in),
    .o_data (data8_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    data_in = 32'hFFFF_0000;
    tick();
    tests_run++;
    if (data_out !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL reset_edge1: got %h expected %h", data_out, 32'h0000_0000);
    end
    tick();
    tests_run++;
    if (data_out !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL reset_edge2: got %h expected %h", data_out, 32'h0000_0000);
    end
  endtask

  task automatic test_release();
    rst_n   = 1'b1;
    data_in = 32'hFFFF_00FF;
    #2;
    tests_run++;
    if (data_out !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL release_before_edge: got %h expected %h", data_out, 32'h0000_0000);
    end
    tick();
    tests_run++;
    if (data_out !== 32'hFFFF_00FF) begin
      tests_failed++;
      $display("FAIL release_after_edge: got %h expected %h", data_out, 32'hFFFF_00FF);
    end
  endtask

  task automatic test_midcycle();
    data_in = 32'hFFFF_FFFF;
    tick();
    tests_run++;
    if (data_out !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL all_ones: got %h expected %h", data_out, 32'hFFFF_FFFF);
    end
    #3;
    data_in = 32'h1234_5678;
    #2;
    tests_run++;
    if (data_out !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL midcycle_hold: got %h expected %h", data_out, 32'hFFFF_FFFF);
    end
    tick();
    tests_run++;
    if (data_out !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL midcycle_next_edge: got %h expected %h", data_out, 32'h1234_5678);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [0:3];
    vec[0] = 32'hDEAD_BEEF;
    vec[1] = 32'h8000_0001;
    vec[2] = 32'h0000_0000;
    vec[3] = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      data_in = vec[i];
      tick();
      tests_run++;
      if (data_out !== vec[i]) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, data_out, vec[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    data_in = 32'hFFFF_FFFF;
    tick();
    tests_run++;
    if (data_out !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL midop_preload: got %h expected %h", data_out, 32'hFFFF_FFFF);
    end
    rst_n   = 1'b0;
    data_in = 32'h0BAD_F00D;
    tick();
    tests_run++;
    if (data_out !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL midop_reset: got %h expected %h", data_out, 32'h0000_0000);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (data_out !== 32'h0BAD_F00D) begin
      tests_failed++;
      $display("FAIL midop_release: got %h expected %h", data_out, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_glitch();
    data_in = 32'hCAFE_0001;
    tick();
    data_in = 32'hCAFE_0002;
    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (data_out !== 32'hCAFE_0001) begin
      tests_failed++;
      $display("FAIL glitch_between_edges: got %h expected %h", data_out, 32'hCAFE_0001);
    end
    tick();
    tests_run++;
    if (data_out !== 32'hCAFE_0002) begin
      tests_failed++;
      $display("FAIL glitch_next_edge: got %h expected %h", data_out, 32'hCAFE_0002);
    end
  endtask

  task automatic test_width8();
    rst8_n   = 1'b0;
    data8_in = 8'h3C;
    tick();
    tests_run++;
    if (data8_out !== 8'hA5) begin
      tests_failed++;
      $display("FAIL w8_reset: got %h expected %h", data8_out, 8'hA5);
    end
    rst8_n = 1'b1;
    tick();
    tests_run++;
    if (data8_out !== 8'h3C) begin
      tests_failed++;
      $display("FAIL w8_load: got %h expected %h", data8_out, 8'h3C);
    end
    data8_in = 8'hC3;
    tick();
    tests_run++;
    if (data8_out !== 8'hC3) begin
      tests_failed++;
      $display("FAIL w8_load2: got %h expected %h", data8_out, 8'hC3);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    data_in      = 32'h0000_0000;
    rst8_n       = 1'b1;
    data8_in     = 8'h00;
    test_reset();
    test_release();
    test_midcycle();
    test_back_to_back();
    test_reset_mid_op();
    test_glitch();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
